uart_rx_cfg: RTL



---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_cfg_if.sv | 30 +++
 rtl/uart_rx_sampler.sv | 49 ++++
 rtl/uart_rx_cfg.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 4;

  // Expected parity bit given the XOR of the data bits and the parity type
  function automatic logic expected_parity(input logic par_typ, input logic data_xor);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Bus bundle between the UART receiver and its user: serial line, frame
// configuration and the received-word / status outputs.
interface uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VLD;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  STRT_GLITCH;
  logic                  BUSY;

  // Side that drives the line and configuration, consumes received words
  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY
  );

  // Receiver side
  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    output P_DATA, DATA_VLD, PAR_ERR, STP_ERR, STRT_GLITCH, BUSY
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timing and 3-sample majority vote for the UART receiver.
// edge_cnt runs 0..P-1 while a frame is active and sits at 0 when idle, so a
// new frame always begins counting from 0.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  rx_s_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic                  sample_pt_o,
  output logic                  vote_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] half;
  logic                  cap0_q, cap1_q;

  assign half = prescale_i >> 1;

  // Next bit-period count: wrap at P-1, held at 0 while idle
  always_comb begin
    edge_cnt_d = '0;
    if (run_i) begin
      if (edge_cnt_q == prescale_i - PRESCALE_W'(1)) edge_cnt_d = '0;
      else                                          edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  // Counter and the two early captures at P/2-1 and P/2
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      cap0_q     <= 1'b1;
      cap1_q     <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (run_i && (edge_cnt_q == half - PRESCALE_W'(1))) cap0_q <= rx_s_i;
      if (run_i && (edge_cnt_q == half))                  cap1_q <= rx_s_i;
    end
  end

  assign edge_cnt_o  = edge_cnt_q;
  assign sample_pt_o = run_i && (edge_cnt_q == half + PRESCALE_W'(1));
  assign vote_o      = (cap0_q & cap1_q) | (cap0_q & rx_s_i) | (cap1_q & rx_s_i);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: input synchroniser, frame FSM, data
// shift register and error flags. Configuration is captured at frame start
// so the user may change it freely while a frame is in flight.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_cfg_if.slave bus
);

  localparam int                    BW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0]         LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall;

  state_t                 state_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   par_flag_q, stp_flag_q;
  logic [PRESCALE_W-1:0]  p_q, p_clamped;
  logic                   par_en_q, par_typ_q, stop2_q;

  logic [DATA_WIDTH-1:0]  p_data_q;
  logic                   data_vld_q, par_err_q, stp_err_q, glitch_q, busy_q;

  logic [PRESCALE_W-1:0]  edge_cnt;
  logic                   sample_pt, vote, bit_end, final_stop, frame_ok;

  // Metastability synchroniser, idles high like the line
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Previous synchronised level for falling-edge start detection
  always_ff @(posedge CLK) begin
    if (RST) rx_prev_q <= 1'b1;
    else     rx_prev_q <= rx_s;
  end

  // Edge, not level: a line stuck low cannot start a new frame
  assign fall      = rx_prev_q & ~rx_s;
  assign p_clamped = (bus.PRESCALE < MIN_P) ? MIN_P : bus.PRESCALE;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .run_i       (state_q != IDLE),
    .prescale_i  (p_q),
    .rx_s_i      (rx_s),
    .edge_cnt_o  (edge_cnt),
    .sample_pt_o (sample_pt),
    .vote_o      (vote)
  );

  assign bit_end    = (edge_cnt == p_q - PRESCALE_W'(1));
  assign final_stop = (bit_cnt_q == BW'(stop2_q));
  // Frame is good only if no earlier error and the final stop bit is high
  assign frame_ok   = ~par_flag_q & ~stp_flag_q & vote;

  // Frame FSM with registered status pulses and received word
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      p_q        <= MIN_P;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop2_q    <= 1'b0;
      p_data_q   <= '0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      glitch_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      glitch_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q    <= START;
            busy_q     <= 1'b1;
            p_q        <= p_clamped;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            stop2_q    <= bus.STOP2;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            bit_cnt_q  <= '0;
          end
        end
        START: begin
          if (sample_pt && vote) begin
            glitch_q <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else if (bit_end) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (sample_pt) shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == LAST) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        PARITY: begin
          if (sample_pt && (vote != expected_parity(par_typ_q, ^shift_q))) par_flag_q <= 1'b1;
          if (bit_end) state_q <= STOP;
        end
        STOP: begin
          if (sample_pt && final_stop) begin
            // Leave mid-bit so a back-to-back start edge is not missed
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            data_vld_q <= frame_ok;
            par_err_q  <= par_flag_q;
            stp_err_q  <= stp_flag_q | ~vote;
            if (frame_ok) p_data_q <= shift_q;
          end else begin
            if (sample_pt && !vote) stp_flag_q <= 1'b1;
            if (bit_end) bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P_DATA      = p_data_q;
  assign bus.DATA_VLD    = data_vld_q;
  assign bus.PAR_ERR     = par_err_q;
  assign bus.STP_ERR     = stp_err_q;
  assign bus.STRT_GLITCH = glitch_q;
  assign bus.BUSY        = busy_q;

endmodule
